// File: rtl/cc_punct_enc.sv
// K=7 convolutional encoder (G1=171, G2=133 octal) with a multi-bit input beat, zero-tail flush
// and run-time puncturing to rate 1/2, 2/3, 3/4 or 5/6; emits a bit-serial stream.
module cc_punct_enc #(
  parameter int unsigned IN_W    = 1,
  parameter bit          TAIL_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [1:0]      cc_rate_i,
  input  logic [IN_W-1:0] in_data_i,
  input  logic            in_valid_i,
  input  logic            in_last_i,
  output logic            in_ready_o,
  output logic            out_bit_o,
  output logic            out_valid_o,
  output logic            out_last_o,
  input  logic            out_ready_i
);

  localparam int unsigned CntW = $clog2(IN_W + 1);

  typedef enum logic [1:0] {StIdle, StRun, StTail, StDrain} state_e;

  state_e            state_q, state_d;
  logic [5:0]        s_q, s_d;
  logic [2:0]        p_q, p_d;
  logic [1:0]        rate_q, rate_d;
  logic [IN_W-1:0]   buf_q, buf_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              last_q, last_d;
  logic [2:0]        tail_q, tail_d;
  logic [1:0]        pend_q, pend_d;
  logic [1:0]        pend_cnt_q, pend_cnt_d;
  logic              pend_last_q, pend_last_d;
  logic              rdy_en_q;

  logic step_ok, step_run, step_tail, step, fire, accept;
  logic bit_in, x, y, keep_x, keep_y, p_wrap;

  assign out_valid_o = (pend_cnt_q != 2'd0);
  assign out_bit_o   = pend_q[0] & out_valid_o;
  assign out_last_o  = pend_last_q && (pend_cnt_q == 2'd1);
  assign fire        = out_valid_o && out_ready_i;

  // A step may only run if the pending register ends the cycle empty.
  assign step_ok   = (pend_cnt_q == 2'd0) || ((pend_cnt_q == 2'd1) && out_ready_i);
  assign step_run  = (state_q == StRun) && (cnt_q != '0) && step_ok;
  assign step_tail = (state_q == StTail) && step_ok;
  assign step      = step_run || step_tail;

  assign bit_in = step_run ? buf_q[0] : 1'b0;
  assign x      = bit_in ^ s_q[0] ^ s_q[1] ^ s_q[2] ^ s_q[5];
  assign y      = bit_in ^ s_q[1] ^ s_q[2] ^ s_q[4] ^ s_q[5];

  // Position 0 keeps both; beyond that odd positions keep Y and even ones keep X.
  assign keep_x = ~p_q[0];
  assign keep_y = (p_q == 3'd0) || p_q[0];

  always_comb begin
    p_wrap = 1'b1;
    case (rate_q)
      2'd0:    p_wrap = 1'b1;
      2'd1:    p_wrap = (p_q == 3'd1);
      2'd2:    p_wrap = (p_q == 3'd2);
      default: p_wrap = (p_q == 3'd4);
    endcase
  end

  assign in_ready_o = rdy_en_q && ((state_q == StIdle) || (state_q == StRun)) && !last_q &&
                      ((cnt_q == '0) || ((cnt_q == CntW'(1)) && step_run));
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    p_d         = p_q;
    rate_d      = rate_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    tail_d      = tail_q;
    pend_d      = pend_q;
    pend_cnt_d  = pend_cnt_q;
    pend_last_d = pend_last_q;

    if (step) begin
      s_d = {s_q[4:0], bit_in};
      p_d = p_wrap ? 3'd0 : p_q + 3'd1;
      if (keep_x && keep_y) begin
        pend_d     = {y, x};
        pend_cnt_d = 2'd2;
      end else begin
        pend_d     = {1'b0, keep_x ? x : y};
        pend_cnt_d = 2'd1;
      end
    end else if (fire) begin
      pend_d     = {1'b0, pend_q[1]};
      pend_cnt_d = pend_cnt_q - 2'd1;
    end

    if (step_run) begin
      buf_d = buf_q >> 1;
      cnt_d = cnt_q - CntW'(1);
      if ((cnt_q == CntW'(1)) && last_q) begin
        last_d = 1'b0;
        if (TAIL_EN) begin
          state_d = StTail;
          tail_d  = 3'd0;
        end else begin
          state_d     = StDrain;
          pend_last_d = 1'b1;
        end
      end
    end

    if (step_tail) begin
      tail_d = tail_q + 3'd1;
      if (tail_q == 3'd5) begin
        state_d     = StDrain;
        pend_last_d = 1'b1;
      end
    end

    if ((state_q == StDrain) && fire && out_last_o) begin
      state_d     = StIdle;
      s_d         = '0;
      p_d         = '0;
      pend_last_d = 1'b0;
    end

    // A newly accepted beat overrides the shift of the one being consumed.
    if (accept) begin
      buf_d  = in_data_i;
      cnt_d  = CntW'(IN_W);
      last_d = in_last_i;
      if (state_q == StIdle) begin
        rate_d  = cc_rate_i;
        state_d = StRun;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      s_q         <= '0;
      p_q         <= '0;
      rate_q      <= '0;
      buf_q       <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      tail_q      <= '0;
      pend_q      <= '0;
      pend_cnt_q  <= '0;
      pend_last_q <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      p_q         <= p_d;
      rate_q      <= rate_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      tail_q      <= tail_d;
      pend_q      <= pend_d;
      pend_cnt_q  <= pend_cnt_d;
      pend_last_q <= pend_last_d;
      rdy_en_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cc_punct_enc.sv
// Bench for cc_punct_enc: fixed impulse vectors, random blocks against an arithmetic reference,
// stalls, mid-block rate changes and mid-block reset. Drives an IN_W=1 and an IN_W=8 instance.
module tb_cc_punct_enc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel;
  logic [1:0] cc_rate;
  logic [7:0] in_data;
  logic       in_valid, in_last, out_ready;
  logic       v1, v8, in_ready;
  logic       rdy1, ob1, ov1, ol1, rdy8, ob8, ov8, ol8;
  logic       ob, ov, ol;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc, first_cyc;
  bit in_q[$];
  bit got_q[$];
  bit exp_q[$];

  typedef struct {
    logic  sel;
    int    rate;
    string din;
    string dout;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign v1       = in_valid & ~sel;
  assign v8       = in_valid & sel;
  assign in_ready = sel ? rdy8 : rdy1;
  assign ob       = sel ? ob8 : ob1;
  assign ov       = sel ? ov8 : ov1;
  assign ol       = sel ? ol8 : ol1;

  cc_punct_enc #(.IN_W(1), .TAIL_EN(1'b1)) u_dut1 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cc_rate_i  (cc_rate),
    .in_data_i  (in_data[0:0]),
    .in_valid_i (v1),
    .in_last_i  (in_last),
    .in_ready_o (rdy1),
    .out_bit_o  (ob1),
    .out_valid_o(ov1),
    .out_last_o (ol1),
    .out_ready_i(out_ready)
  );

  cc_punct_enc #(.IN_W(8), .TAIL_EN(1'b1)) u_dut8 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cc_rate_i  (cc_rate),
    .in_data_i  (in_data),
    .in_valid_i (v8),
    .in_last_i  (in_last),
    .in_ready_o (rdy8),
    .out_bit_o  (ob8),
    .out_valid_o(ov8),
    .out_last_o (ol8),
    .out_ready_i(out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: convolve the tail-extended input with the generator taps, then keep
  // bits according to the per-rate puncture table.
  function automatic void model(input int rate);
    bit u[$];
    int period[4] = '{1, 2, 3, 5};
    logic [4:0] kx[4] = '{5'b00001, 5'b00001, 5'b00101, 5'b10101};
    logic [4:0] ky[4] = '{5'b00001, 5'b00011, 5'b00011, 5'b01011};
    int dx[5] = '{0, 1, 2, 3, 6};
    int dy[5] = '{0, 2, 3, 5, 6};
    bit xb, yb;
    int p;
    u = in_q;
    repeat (6) u.push_back(1'b0);
    exp_q.delete();
    for (int n = 0; n < u.size(); n++) begin
      xb = 1'b0;
      yb = 1'b0;
      for (int k = 0; k < 5; k++) begin
        if (n - dx[k] >= 0) xb ^= u[n - dx[k]];
        if (n - dy[k] >= 0) yb ^= u[n - dy[k]];
      end
      p = n % period[rate];
      if (kx[rate][p]) exp_q.push_back(xb);
      if (ky[rate][p]) exp_q.push_back(yb);
    end
  endfunction

  function automatic void str2q(input string s, output bit q[$]);
    q.delete();
    for (int i = 0; i < s.len(); i++) q.push_back(s[i] == "1");
  endfunction

  task automatic cmp_stream(input string name);
    int mism;
    chk({name, "_len"}, got_q.size(), exp_q.size());
    mism = -1;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (mism < 0 && got_q[i] !== exp_q[i]) mism = i;
    checks++;
    if (mism >= 0) begin
      errors++;
      $display("FAIL %s_bits: first difference at bit %0d, got %0b, expected %0b",
               name, mism, got_q[mism], exp_q[mism]);
    end
  endtask

  // Called #1 after a posedge; returns #1 after a posedge.
  task automatic run_block(input logic s, input int rate, input bit gaps, input bit stall,
                           input bit toggle);
    int w, nb, to, n_out;
    bit done, prev_stall, prev_bit, first;
    logic [7:0] d;
    sel = s;
    w = s ? 8 : 1;
    nb = (in_q.size() + w - 1) / w;
    got_q.delete();
    fork
      begin
        for (int i = 0; i < nb; i++) begin
          if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          d = '0;
          for (int j = 0; j < w; j++) if (i * w + j < in_q.size()) d[j] = in_q[i * w + j];
          in_data  = d;
          in_valid = 1'b1;
          in_last  = (i == nb - 1);
          cc_rate  = (i == 0 || !toggle) ? 2'(rate) : 2'($urandom_range(0, 3));
          to = 0;
          while (to < 500) begin
            @(negedge clk);
            if (in_ready) break;
            @(posedge clk); #1;
            to++;
          end
          if (to >= 500) begin
            chk("accept_timeout", 1, 0);
            in_valid = 1'b0;
            break;
          end
          @(posedge clk); #1;
          if (i == 0) acc_cyc = cyc;
          in_valid = 1'b0;
          in_last  = 1'b0;
        end
      end
      begin
        done = 1'b0;
        prev_stall = 1'b0;
        prev_bit = 1'b0;
        first = 1'b1;
        n_out = 0;
        while (!done && n_out < 4000) begin
          out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
          @(negedge clk);
          if (ov && first) begin
            first_cyc = cyc;
            first = 1'b0;
          end
          if (prev_stall) begin
            checks++;
            if (!ov || ob !== prev_bit) begin
              errors++;
              $display("FAIL hold: got valid=%0b bit=%0b, expected valid=1 bit=%0b", ov, ob,
                       prev_bit);
            end
          end
          prev_stall = ov && !out_ready;
          prev_bit   = ob;
          if (ov && out_ready) begin
            got_q.push_back(ob);
            if (ol) done = 1'b1;
          end
          @(posedge clk); #1;
          n_out++;
        end
        if (!done) chk("out_last_timeout", 0, 1);
      end
    join
    out_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got hang, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; sel = 1'b0; cc_rate = '0; in_data = '0;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;

    tbl[0] = '{1'b0, 0, "1", "11101111000111"};
    tbl[1] = '{1'b0, 1, "1", "11011100111"};
    tbl[2] = '{1'b0, 2, "1", "1101110011"};
    tbl[3] = '{1'b0, 3, "1", "110110011"};
    tbl[4] = '{1'b1, 0, "10000000", "1110111100011100000000000000"};
    tbl[5] = '{1'b1, 0, "00000001", "0000000000000011101111000111"};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {rdy1, ov1, ob1, ol1, rdy8, ov8, ob8, ol8}, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_before_first_clk", {rdy1, rdy8}, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready_after_first_clk", {rdy1, rdy8}, 2'b11);
    @(posedge clk); #1;

    for (int t = 0; t < 6; t++) begin
      str2q(tbl[t].din, in_q);
      str2q(tbl[t].dout, exp_q);
      run_block(tbl[t].sel, tbl[t].rate, 1'b0, 1'b0, 1'b0);
      cmp_stream($sformatf("vec%0d", t));
      chk($sformatf("vec%0d_latency", t), first_cyc, acc_cyc + 1);
    end

    // Random 48-bit blocks at 3/4 and 5/6, 8-bit beats.
    for (int r = 2; r <= 3; r++) begin
      for (int k = 0; k < 2; k++) begin
        in_q.delete();
        repeat (48) in_q.push_back(1'($urandom_range(0, 1)));
        model(r);
        run_block(1'b1, r, 1'b0, 1'b0, 1'b0);
        cmp_stream($sformatf("rand_r%0d_%0d", r, k));
      end
    end

    // Stalled output and input gaps at 5/6 on both widths.
    for (int k = 0; k < 3; k++) begin
      in_q.delete();
      repeat (48) in_q.push_back(1'($urandom_range(0, 1)));
      model(3);
      run_block(k != 2, 3, 1'b1, 1'b1, 1'b0);
      cmp_stream($sformatf("stall_%0d", k));
    end

    // Rate changes mid-block are ignored; the following block uses its own rate.
    for (int k = 0; k < 2; k++) begin
      in_q.delete();
      repeat (48) in_q.push_back(1'($urandom_range(0, 1)));
      model(2);
      run_block(k == 0, 2, 1'b0, 1'b0, 1'b1);
      cmp_stream($sformatf("toggle_%0d", k));
      in_q.delete();
      repeat (16) in_q.push_back(1'($urandom_range(0, 1)));
      model(1);
      run_block(k == 0, 1, 1'b0, 1'b0, 1'b0);
      cmp_stream($sformatf("after_toggle_%0d", k));
    end

    // Reset in the middle of a RUN block, then a clean impulse.
    sel = 1'b0; cc_rate = 2'd0; in_data = 8'h01; in_last = 1'b0; in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("mid_reset_%0d", i), {ov1, rdy1, ob1, ol1}, 4'h0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    str2q("1", in_q);
    str2q("11101111000111", exp_q);
    run_block(1'b0, 0, 1'b0, 1'b0, 1'b0);
    cmp_stream("post_reset_impulse");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
